// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and load/store; data wins, fetch is guarded against starvation.
// Latency: request seen at t -> MEM_REQ from t+1, VALID one cycle after MEM_ACK (or timeout); STALL holds the PC meanwhile.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_VALID,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_VALID,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              STALL,
  output logic              ERR
);

  localparam int          BW       = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic            owner_d;
  logic [BW-1:0]   burst_cnt;
  logic [7:0]      tmo_cnt;
  logic            grant_d, grant_if, tmo_hit;

  // Fetch takes the port only once data has had MAX_D_BURST grants in a row while fetch waited.
  assign grant_d  = D_REQ && !(IF_REQ && (burst_cnt == BURST_MAX));
  assign grant_if = IF_REQ && !grant_d;
  // An ack in the last allowed cycle beats the timeout.
  assign tmo_hit  = (tmo_cnt == TMO_LAST) && !MEM_ACK;

  assign STALL = (IF_REQ && !IF_VALID) || (D_REQ && !D_VALID);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (D_REQ || IF_REQ) state_nxt = BUSY;
      BUSY:    if (MEM_ACK || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_d   <= 1'b0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      IF_RDATA  <= '0;
      D_RDATA   <= '0;
      IF_VALID  <= 1'b0;
      D_VALID   <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            owner_d   <= grant_d;
            MEM_REQ   <= 1'b1;
            MEM_WE    <= grant_d && D_WE;
            MEM_ADDR  <= grant_d ? D_ADDR : IF_ADDR;
            MEM_WDATA <= D_WDATA;
            tmo_cnt   <= '0;
            if (grant_d && IF_REQ)
              burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
            else
              burst_cnt <= '0;
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (MEM_ACK || tmo_hit) begin
            MEM_REQ  <= 1'b0;
            IF_VALID <= !owner_d;
            D_VALID  <= owner_d;
            if (tmo_hit) ERR <= 1'b1;
            if (owner_d) D_RDATA  <= MEM_ACK ? MEM_RDATA : ABORT_DATA;
            else         IF_RDATA <= MEM_ACK ? MEM_RDATA : ABORT_DATA;
          end
        end
        RESP: begin
          IF_VALID <= 1'b0;
          D_VALID  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected memory requests and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mreq_t;
  typedef struct {logic chk; logic [31:0] data;} resp_t;

  logic        CLK, RESET_N;
  logic        IF_REQ, D_REQ, D_WE;
  logic [31:0] IF_ADDR, D_ADDR, D_WDATA;
  logic [31:0] IF_RDATA, D_RDATA, MEM_ADDR, MEM_WDATA;
  logic        IF_VALID, D_VALID, MEM_REQ, MEM_WE, STALL, ERR;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mreq_t mem_q[$];
  resp_t if_q[$];
  resp_t d_q[$];

  // memory model controls
  int          mem_lat = 1;
  bit          mem_fixed_en = 0;
  logic [31:0] mem_fixed = 32'h0;
  bit          inj_ack = 0;
  logic [31:0] inj_data = 32'h0;
  int          mcnt = 0;

  // monitor bookkeeping
  bit mem_prev = 0;
  int req_len = 0;
  int last_req_len = 0;
  int if_valid_cyc = 0;
  int d_valid_cyc = 0;

  mem_port_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_VALID(D_VALID),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .STALL(STALL), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks on the mem_lat-th BUSY cycle (0 = never); inj_ack forces an ack regardless of MEM_REQ.
  always @(negedge CLK) begin
    if (inj_ack) begin
      MEM_ACK   = 1'b1;
      MEM_RDATA = inj_data;
    end else if (MEM_REQ) begin
      mcnt++;
      if (mem_lat != 0 && mcnt == mem_lat) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = mem_fixed_en ? mem_fixed : mem_fn(MEM_ADDR);
      end else begin
        MEM_ACK = 1'b0;
      end
    end else begin
      mcnt    = 0;
      MEM_ACK = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin
    resp_t r;
    mreq_t m;
    if (IF_VALID && D_VALID) chk("both_valid", {IF_VALID, D_VALID}, 2'b01);
    if (IF_VALID) begin
      if_valid_cyc = cyc;
      chk("if_valid_expected", if_q.size() != 0, 1);
      if (if_q.size() != 0) begin
        r = if_q.pop_front();
        if (r.chk) chk("if_rdata", IF_RDATA, r.data);
      end
    end
    if (D_VALID) begin
      d_valid_cyc = cyc;
      chk("d_valid_expected", d_q.size() != 0, 1);
      if (d_q.size() != 0) begin
        r = d_q.pop_front();
        if (r.chk) chk("d_rdata", D_RDATA, r.data);
      end
    end
    if (MEM_REQ && !mem_prev) begin
      req_len = 0;
      chk("mem_req_expected", mem_q.size() != 0, 1);
      if (mem_q.size() != 0) begin
        m = mem_q.pop_front();
        chk("mem_addr", MEM_ADDR, m.addr);
        chk("mem_we", MEM_WE, m.we);
        if (m.we) chk("mem_wdata", MEM_WDATA, m.wdata);
      end
    end
    if (MEM_REQ) req_len++;
    if (!MEM_REQ && mem_prev) last_req_len = req_len;
    mem_prev = MEM_REQ;
  end

  task automatic wait_valid(input bit is_d);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge CLK);
      ok = is_d ? D_VALID : IF_VALID;
    end
    chk(is_d ? "d_done_in_time" : "if_done_in_time", ok, 1);
  endtask

  task automatic if_access(input logic [31:0] a);
    @(posedge CLK); #1;
    IF_ADDR = a;
    IF_REQ  = 1'b1;
    wait_valid(0);
    @(posedge CLK); #1;
    IF_REQ = 1'b0;
  endtask

  // n back-to-back data accesses at base, base+4, ... with D_REQ held high between them.
  task automatic d_seq(input int n, input logic [31:0] base, input logic we, input logic [31:0] wd);
    @(posedge CLK); #1;
    D_WE    = we;
    D_WDATA = wd;
    D_REQ   = 1'b1;
    for (int i = 0; i < n; i++) begin
      D_ADDR = base + 32'(4 * i);
      wait_valid(1);
      @(posedge CLK); #1;
    end
    D_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    IF_REQ = 0; D_REQ = 0; D_WE = 0;
    IF_ADDR = 0; D_ADDR = 0; D_WDATA = 0;
    repeat (2) @(negedge CLK);
    chk("rst_mem_req", MEM_REQ, 0);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_valids", {IF_VALID, D_VALID}, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rdata", IF_RDATA | D_RDATA, 0);
    chk("rst_stall", STALL, 0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // Single fetch with ack on the first BUSY cycle
    mem_lat = 1; mem_fixed_en = 1; mem_fixed = 32'h2008_0005;
    mem_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    if_q.push_back('{chk: 1'b1, data: 32'h2008_0005});
    @(posedge CLK); #1;
    IF_ADDR = 32'h0000_0040;
    IF_REQ  = 1'b1;
    @(negedge CLK);
    chk("t1_stall_t", STALL, 1);
    chk("t1_mem_req_t", MEM_REQ, 0);
    @(negedge CLK);
    chk("t1_stall_busy", STALL, 1);
    chk("t1_mem_req_t1", MEM_REQ, 1);
    chk("t1_mem_we", MEM_WE, 0);
    @(negedge CLK);
    chk("t1_if_valid_t2", IF_VALID, 1);
    chk("t1_d_valid_t2", D_VALID, 0);
    chk("t1_mem_req_t2", MEM_REQ, 0);
    @(posedge CLK); #1;
    IF_REQ = 1'b0;
    @(negedge CLK);
    chk("t1_if_valid_pulse", IF_VALID, 0);
    chk("t1_stall_after", STALL, 0);
    chk("t1_req_len", last_req_len, 1);

    // Simultaneous store and fetch: store first
    mem_lat = 3; mem_fixed_en = 0;
    mem_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hA5A5_A5A5});
    mem_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    d_q.push_back('{chk: 1'b0, data: 32'h0});
    if_q.push_back('{chk: 1'b1, data: mem_fn(32'h44)});
    fork
      d_seq(1, 32'h100, 1'b1, 32'hA5A5_A5A5);
      if_access(32'h44);
    join
    chk("t2_if_after_d", if_valid_cyc > d_valid_cyc, 1);
    chk("t2_store_len", last_req_len >= 3, 1);

    // Continuous data with fetch waiting: 4 data grants, fetch, then data again
    mem_lat = 2;
    for (int i = 0; i < 4; i++) mem_q.push_back('{we: 1'b0, addr: 32'h300 + 32'(4 * i), wdata: 32'h0});
    mem_q.push_back('{we: 1'b0, addr: 32'h60, wdata: 32'h0});
    for (int i = 4; i < 6; i++) mem_q.push_back('{we: 1'b0, addr: 32'h300 + 32'(4 * i), wdata: 32'h0});
    for (int i = 0; i < 6; i++) d_q.push_back('{chk: 1'b1, data: mem_fn(32'h300 + 32'(4 * i))});
    if_q.push_back('{chk: 1'b1, data: mem_fn(32'h60)});
    fork
      d_seq(6, 32'h300, 1'b0, 32'h0);
      if_access(32'h60);
    join
    chk("t3_if_before_last_d", if_valid_cyc < d_valid_cyc, 1);

    // Unresponsive memory: timeout abort, sticky ERR
    mem_lat = 0;
    mem_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    d_q.push_back('{chk: 1'b1, data: 32'hDEAD_BEEF});
    d_seq(1, 32'h200, 1'b0, 32'h0);
    chk("t4_tmo_req_len", last_req_len, 255);
    chk("t4_err_set", ERR, 1);
    mem_lat = 2;
    mem_q.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
    if_q.push_back('{chk: 1'b1, data: mem_fn(32'h48)});
    if_access(32'h48);
    chk("t4_err_sticky", ERR, 1);
    chk("t4_d_rdata_kept", D_RDATA, 32'hDEAD_BEEF);

    // Reset in the middle of BUSY
    mem_lat = 0;
    mem_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
    @(posedge CLK); #1;
    IF_ADDR = 32'h80;
    IF_REQ  = 1'b1;
    repeat (5) @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    chk("t5_mem_req", MEM_REQ, 0);
    chk("t5_mem_addr", MEM_ADDR, 0);
    chk("t5_valids", {IF_VALID, D_VALID}, 0);
    chk("t5_err", ERR, 0);
    chk("t5_rdata", IF_RDATA | D_RDATA, 0);
    IF_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    mem_lat = 1;
    mem_q.push_back('{we: 1'b0, addr: 32'h84, wdata: 32'h0});
    if_q.push_back('{chk: 1'b1, data: mem_fn(32'h84)});
    if_access(32'h84);
    chk("t5_err_after", ERR, 0);

    // Stray ack while idle is ignored
    @(posedge CLK); #1;
    inj_data = 32'h1234;
    inj_ack  = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t6_mem_req", MEM_REQ, 0);
    chk("t6_if_rdata", IF_RDATA, mem_fn(32'h84));
    chk("t6_d_rdata", D_RDATA, 0);
    @(posedge CLK); #1;
    inj_ack = 1'b0;
    repeat (2) @(posedge CLK);
    mem_lat = 2;
    mem_q.push_back('{we: 1'b0, addr: 32'h88, wdata: 32'h0});
    if_q.push_back('{chk: 1'b1, data: mem_fn(32'h88)});
    if_access(32'h88);
    chk("t6_req_len_after", last_req_len, 2);

    repeat (3) @(posedge CLK);
    chk("end_mem_q_empty", mem_q.size(), 0);
    chk("end_if_q_empty", if_q.size(), 0);
    chk("end_d_q_empty", d_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
